// File: rtl/global_mem_scheduler.sv
// -----------------------------------------------------------------------------
// global_mem_scheduler
// Round-robin arbiter for the cluster's single-port global memory/device bus.
// A registered one-hot grant drives each core's shared_ready. A core that keeps
// request and lock asserted may hold the bus for up to MAX_HOLD consecutive
// cycles. A per-core read-return strobe follows the one-cycle memory read
// latency.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset_n        asynchronous active-low reset
//   request        per-core bus request (level)
//   lock           per-core hold request (only meaningful for the granted core)
//   shared_rden    read enable driven on the shared bus by the granted core
//   grant_oh       registered one-hot grant (zero = bus idle)
//   grant_id       binary index of the grant_oh bit, 0 when idle
//   grant_valid    OR of grant_oh
//   read_valid_oh  one-hot owner of the shared read data this cycle
// -----------------------------------------------------------------------------
module global_mem_scheduler #(
    parameter int NUM_REQUESTERS = 16,
    parameter int MAX_HOLD       = 8,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic [NUM_REQUESTERS-1:0] lock,
    input  logic                      shared_rden,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [ID_WIDTH-1:0]       grant_id,
    output logic                      grant_valid,
    output logic [NUM_REQUESTERS-1:0] read_valid_oh
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [ID_WIDTH-1:0]       ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
    logic [NUM_REQUESTERS-1:0] grant_oh_r, grant_nxt_s;
    logic [ID_WIDTH-1:0]       grant_id_r, grant_id_nxt_s;
    logic                      grant_valid_r;
    logic [NUM_REQUESTERS-1:0] read_valid_oh_r;
    logic [ID_WIDTH:0]         pick_all_s, pick_skip_s;
    logic                      own_lock_s;

    // Round-robin search starting after ptr. With skip_owner set, the current
    // owner (ptr itself) is excluded so a core leaving a locked hold cannot
    // immediately win the bus back. Returns {found, index}.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_REQUESTERS-1:0] req,
        input logic [ID_WIDTH-1:0]       ptr,
        input logic                      skip_owner
    );
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        int                  cand;
        int                  span;
        found = 1'b0;
        idx   = {ID_WIDTH{1'b0}};
        span  = skip_owner ? (NUM_REQUESTERS - 1) : NUM_REQUESTERS;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            if ((int'(ptr) + i) >= NUM_REQUESTERS) begin
                cand = int'(ptr) + i - NUM_REQUESTERS;
            end else begin
                cand = int'(ptr) + i;
            end
            if (!found && (i <= span) && req[cand]) begin
                found = 1'b1;
                idx   = ID_WIDTH'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            ptr_r           <= ID_WIDTH'(NUM_REQUESTERS - 1);
            cnt_r           <= {CNT_W{1'b0}};
            grant_oh_r      <= {NUM_REQUESTERS{1'b0}};
            grant_id_r      <= {ID_WIDTH{1'b0}};
            grant_valid_r   <= 1'b0;
            read_valid_oh_r <= {NUM_REQUESTERS{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            ptr_r           <= ptr_nxt_s;
            cnt_r           <= cnt_nxt_s;
            grant_oh_r      <= grant_nxt_s;
            grant_id_r      <= grant_id_nxt_s;
            grant_valid_r   <= (state_nxt_s != ST_IDLE);
            // Read data returns one cycle after the read was issued, owned by
            // whoever held the bus when it was issued.
            read_valid_oh_r <= grant_oh_r & {NUM_REQUESTERS{shared_rden}};
        end
    end

    // Next-state logic: arbitration, hold entry/exit, pointer update.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        pick_all_s  = rr_pick(request, ptr_r, 1'b0);
        pick_skip_s = rr_pick(request, ptr_r, 1'b1);
        // While granted, ptr_r is the owner's index.
        own_lock_s  = request[ptr_r] & lock[ptr_r];
        case (state_r)
            ST_IDLE, ST_GRANT: begin
                if ((state_r == ST_GRANT) && own_lock_s && (MAX_HOLD > 1)) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = CNT_W'(1);
                end else if (pick_all_s[ID_WIDTH]) begin
                    state_nxt_s = ST_GRANT;
                    ptr_nxt_s   = pick_all_s[ID_WIDTH-1:0];
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            ST_HOLD: begin
                if (own_lock_s && (cnt_r < CNT_W'(MAX_HOLD - 1))) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else if (pick_skip_s[ID_WIDTH]) begin
                    state_nxt_s = ST_GRANT;
                    ptr_nxt_s   = pick_skip_s[ID_WIDTH-1:0];
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode of the next grant; registered in the state process.
    always_comb begin
        grant_nxt_s    = {NUM_REQUESTERS{1'b0}};
        grant_id_nxt_s = {ID_WIDTH{1'b0}};
        if (state_nxt_s != ST_IDLE) begin
            grant_nxt_s    = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << ptr_nxt_s;
            grant_id_nxt_s = ptr_nxt_s;
        end else begin
            grant_nxt_s    = {NUM_REQUESTERS{1'b0}};
            grant_id_nxt_s = {ID_WIDTH{1'b0}};
        end
    end

    assign grant_oh      = grant_oh_r;
    assign grant_id      = grant_id_r;
    assign grant_valid   = grant_valid_r;
    assign read_valid_oh = read_valid_oh_r;

endmodule

// File: tb/tb_global_mem_scheduler.sv
// Self-checking bench for global_mem_scheduler. A behavioural model tracks the
// bus owner, the round-robin pointer and the consecutive-grant run length.
module tb_global_mem_scheduler;

    localparam int N  = 16;
    localparam int MH = 8;
    localparam int IW = 4;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  request;
    logic [N-1:0]  lock;
    logic          shared_rden;
    logic [N-1:0]  grant_oh;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic [N-1:0]  read_valid_oh;

    int checks;
    int failures;

    // Model state
    int           m_owner;
    int           m_ptr;
    int           m_consec;
    logic [N-1:0] exp_gnt;
    logic [IW-1:0] exp_id;
    logic         exp_valid;
    logic [N-1:0] exp_rv;

    global_mem_scheduler #(.NUM_REQUESTERS(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset_n(reset_n), .request(request), .lock(lock),
        .shared_rden(shared_rden), .grant_oh(grant_oh), .grant_id(grant_id),
        .grant_valid(grant_valid), .read_valid_oh(read_valid_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = N - 1;
        m_consec  = 0;
        exp_gnt   = '0;
        exp_id    = '0;
        exp_valid = 1'b0;
        exp_rv    = '0;
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        int           nxt;
        int           span;
        int           c;
        logic [N-1:0] one;
        one = 1;
        exp_rv = (m_owner >= 0 && shared_rden) ? (one << m_owner) : '0;
        if (m_owner >= 0 && request[m_owner] && lock[m_owner] && m_consec < MH) begin
            m_consec = m_consec + 1;
        end else begin
            // Leaving a locked run: the previous owner sits out one search.
            span = (m_consec >= 2) ? N - 1 : N;
            nxt = -1;
            for (int i = 1; i <= span; i++) begin
                c = (m_ptr + i) % N;
                if (nxt < 0 && request[c]) nxt = c;
            end
            m_owner = nxt;
            if (nxt >= 0) begin
                m_ptr    = nxt;
                m_consec = 1;
            end else begin
                m_consec = 0;
            end
        end
        exp_gnt   = (m_owner >= 0) ? (one << m_owner) : '0;
        exp_id    = (m_owner >= 0) ? IW'(m_owner) : '0;
        exp_valid = (m_owner >= 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; request = '0; lock = '0; shared_rden = 1'b0;
        model_reset();
        #3;
        checks++;
        if (grant_oh !== 16'h0000 || grant_valid !== 1'b0 || grant_id !== 4'd0 || read_valid_oh !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs grant_oh=%h valid=%b id=%0d rv=%h expected all zero", grant_oh, grant_valid, grant_id, read_valid_oh);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (grant_oh !== 16'h0000 || grant_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d grant_oh=%h valid=%b expected 0000 0", i, grant_oh, grant_valid);
            end
        end
        request = 16'h0010;
        tick();
        checks++;
        if (grant_oh !== 16'h0010 || grant_id !== 4'd4 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_grant grant_oh=%h id=%0d valid=%b expected 0010 4 1", grant_oh, grant_id, grant_valid);
        end
    endtask

    task automatic test_rotate();
        // Park the pointer on core 15 so the rotation starts at core 0.
        request = 16'h8000; lock = '0;
        tick();
        request = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            tick();
            checks++;
            if (grant_id !== IW'(i % N) || grant_oh !== (16'h0001 << (i % N)) || grant_oh !== exp_gnt) begin
                failures++;
                $display("FAIL rotate cyc=%0d grant_oh=%h id=%0d expected id %0d model %h", i, grant_oh, grant_id, i % N, exp_gnt);
            end
        end
    endtask

    task automatic test_hold();
        int run1;
        int max_run1;
        int run2_bad;
        int prev;
        request = 16'h0006; lock = 16'h0002;
        run1 = 0; max_run1 = 0; run2_bad = 0; prev = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (grant_oh !== exp_gnt || grant_id !== exp_id || grant_valid !== exp_valid) begin
                failures++;
                $display("FAIL hold cyc=%0d grant_oh=%h id=%0d expected %h %0d", i, grant_oh, grant_id, exp_gnt, exp_id);
            end
            if (grant_oh == 16'h0002) begin
                run1 = run1 + 1;
                if (run1 > max_run1) max_run1 = run1;
            end else begin
                run1 = 0;
            end
            if (grant_oh == 16'h0004 && prev == 2) run2_bad++;
            prev = (grant_oh == 16'h0004) ? 2 : ((grant_oh == 16'h0002) ? 1 : 0);
        end
        checks++;
        if (max_run1 !== 8 || run2_bad !== 0) begin
            failures++;
            $display("FAIL hold_run core1_max_run=%0d core2_double=%0d expected 8 0", max_run1, run2_bad);
        end
        request = '0; lock = '0;
        tick();
    endtask

    task automatic test_lock_drop();
        request = 16'h0008; lock = 16'h0008;
        tick();
        checks++;
        if (grant_oh !== 16'h0008) begin
            failures++;
            $display("FAIL lockdrop_grant grant_oh=%h expected 0008", grant_oh);
        end
        for (int i = 0; i < 4; i++) tick();
        request = 16'h0108; lock = '0;
        tick();
        checks++;
        if (grant_oh !== 16'h0100 || grant_id !== 4'd8 || grant_oh !== exp_gnt) begin
            failures++;
            $display("FAIL lockdrop_next grant_oh=%h id=%0d expected 0100 8", grant_oh, grant_id);
        end
        request = '0;
        tick();
    endtask

    task automatic test_read_valid();
        request = 16'h0020; lock = '0; shared_rden = 1'b0;
        tick();
        shared_rden = 1'b1;
        tick();
        checks++;
        if (read_valid_oh !== 16'h0020 || read_valid_oh !== exp_rv) begin
            failures++;
            $display("FAIL read_valid_t1 rv=%h expected 0020", read_valid_oh);
        end
        shared_rden = 1'b0; request = '0;
        tick();
        checks++;
        if (read_valid_oh !== 16'h0000 || grant_oh !== 16'h0000) begin
            failures++;
            $display("FAIL read_valid_t2 rv=%h grant_oh=%h expected 0000 0000", read_valid_oh, grant_oh);
        end
        shared_rden = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (read_valid_oh !== 16'h0000) begin
                failures++;
                $display("FAIL read_valid_idle cyc=%0d rv=%h expected 0000", i, read_valid_oh);
            end
        end
        shared_rden = 1'b0;
    endtask

    task automatic test_async_reset();
        request = 16'h0080; lock = 16'h0080;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (grant_oh !== 16'h0080) begin
            failures++;
            $display("FAIL areset_setup grant_oh=%h expected 0080", grant_oh);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (grant_oh !== 16'h0000 || grant_valid !== 1'b0 || grant_id !== 4'd0 || read_valid_oh !== 16'h0000) begin
            failures++;
            $display("FAIL areset_async grant_oh=%h valid=%b id=%0d rv=%h expected all zero", grant_oh, grant_valid, grant_id, read_valid_oh);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        request = 16'h0081; lock = '0;
        tick();
        checks++;
        if (grant_oh !== 16'h0001 || grant_id !== 4'd0) begin
            failures++;
            $display("FAIL areset_first grant_oh=%h id=%0d expected 0001 0", grant_oh, grant_id);
        end
        request = '0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            request     = N'($urandom) & N'($urandom);
            lock        = N'($urandom) | N'($urandom);
            shared_rden = 1'($urandom);
            tick();
            checks++;
            if (grant_oh !== exp_gnt || grant_id !== exp_id || grant_valid !== exp_valid || read_valid_oh !== exp_rv) begin
                failures++;
                $display("FAIL random cyc=%0d grant_oh=%h id=%0d v=%b rv=%h expected %h %0d %b %h",
                         i, grant_oh, grant_id, grant_valid, read_valid_oh, exp_gnt, exp_id, exp_valid, exp_rv);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_rotate();
        test_hold();
        test_lock_drop();
        test_read_valid();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
